// File: rtl/snax_gemmx_launch_ctrl_if.sv
// Bundles the CSR-manager handshake and accelerator config/status wires of the launch sequencer.
// Latency: none, wires only.
// Backpressure: carried by the valid/ready pairs; slave modport is the launch controller's view.
interface snax_gemmx_launch_ctrl_if #(
   parameter int unsigned RegRWCount   = 10,
   parameter int unsigned RegROCount   = 2,
   parameter int unsigned RegDataWidth = 32
);
   logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i;
   logic                               csr_reg_set_valid_i;
   logic                               csr_reg_set_ready_o;
   logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o;
   logic [4*RegDataWidth-1:0]          gemm_cfg_o;
   logic                               gemm_cfg_valid_o;
   logic                               gemm_cfg_ready_i;
   logic [4*RegDataWidth-1:0]          simd_cfg_o;
   logic                               simd_cfg_valid_o;
   logic                               simd_cfg_ready_i;
   logic                               bypass_simd_o;
   logic                               acc_busy_i;

   // Launch controller side.
   modport slave (
      input  csr_reg_set_i, csr_reg_set_valid_i, gemm_cfg_ready_i, simd_cfg_ready_i, acc_busy_i,
      output csr_reg_set_ready_o, csr_reg_ro_set_o, gemm_cfg_o, gemm_cfg_valid_o,
             simd_cfg_o, simd_cfg_valid_o, bypass_simd_o
   );

   // CSR manager plus accelerator side.
   modport master (
      output csr_reg_set_i, csr_reg_set_valid_i, gemm_cfg_ready_i, simd_cfg_ready_i, acc_busy_i,
      input  csr_reg_set_ready_o, csr_reg_ro_set_o, gemm_cfg_o, gemm_cfg_valid_o,
             simd_cfg_o, simd_cfg_valid_o, bypass_simd_o
   );
endinterface

// File: rtl/snax_gemmx_launch_ctrl.sv
// Forks one CSR config set into independent GEMM/SIMD config handshakes and tracks the job until idle.
// Latency: config valids rise the cycle after accept; RUN starts the cycle after the last config handshake.
// Backpressure: csr ready only in IDLE; config valids held until accepted. Watchdog macro: SNAX_GEMMX_LAUNCH_TIMEOUT_EN.
module snax_gemmx_launch_ctrl #(
   parameter int unsigned RegRWCount    = 10,
   parameter int unsigned RegROCount    = 2,
   parameter int unsigned RegDataWidth  = 32,
   parameter int unsigned TimeoutCycles = 1048576
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   snax_gemmx_launch_ctrl_if.slave bus
);
   localparam int unsigned W = RegDataWidth;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DISPATCH = 2'd1,
      RUN      = 2'd2
   } state_e;

   state_e         state_q, state_d;
   logic [4*W-1:0] gemm_cfg_q, simd_cfg_q;
   logic           bypass_q;
   logic           gemm_done_q, simd_done_q;
   logic [W-1:0]   cycle_cnt_q;
   logic           set_rdy, gemm_vld, simd_vld;
   logic           accept, job_active, timeout, err;
   logic           unused_csr_bits;

   assign accept     = bus.csr_reg_set_valid_i & set_rdy;
   assign job_active = (state_q != IDLE);

   // Only bit 0 of CSR8 has a meaning; the rest of CSR8 and anything above it is ignored.
   assign unused_csr_bits = ^bus.csr_reg_set_i[RegRWCount*W-1:8*W+1];

`ifdef SNAX_GEMMX_LAUNCH_TIMEOUT_EN
   logic [31:0] wd_cnt_q;
   logic        err_q;

   assign timeout = job_active && (wd_cnt_q >= TimeoutCycles);
   assign err     = err_q;

   // Watchdog: counts job cycles since accept and latches a sticky error when the limit is hit.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else if (accept) begin
         wd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (job_active && !timeout) wd_cnt_q <= wd_cnt_q + 32'd1;
         if (timeout)                err_q    <= 1'b1;
      end
   end
`else
   assign timeout = 1'b0;
   assign err     = 1'b0;

   // TimeoutCycles only has an effect when the watchdog is compiled in.
   if (TimeoutCycles == 0) begin : g_no_watchdog
   end
`endif

   // State register; async reset drops both valids immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state plus handshake outputs; a target's valid stays low once its done flag is set.
   always_comb begin
      state_d  = state_q;
      set_rdy  = 1'b0;
      gemm_vld = 1'b0;
      simd_vld = 1'b0;
      case (state_q)
         IDLE: begin
            set_rdy = rst_ni;
            if (bus.csr_reg_set_valid_i && rst_ni) state_d = DISPATCH;
         end
         DISPATCH: begin
            gemm_vld = !gemm_done_q && !timeout;
            simd_vld = !simd_done_q && !timeout;
            if (timeout)
               state_d = IDLE;
            else if ((gemm_done_q || bus.gemm_cfg_ready_i) && (simd_done_q || bus.simd_cfg_ready_i))
               state_d = RUN;
         end
         RUN: begin
            if (timeout || !bus.acc_busy_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Config capture on accept, sticky per-target done flags and the saturating job cycle counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gemm_cfg_q  <= '0;
         simd_cfg_q  <= '0;
         bypass_q    <= 1'b0;
         gemm_done_q <= 1'b0;
         simd_done_q <= 1'b0;
         cycle_cnt_q <= '0;
      end else if (accept) begin
         gemm_cfg_q  <= bus.csr_reg_set_i[4*W-1:0];
         simd_cfg_q  <= bus.csr_reg_set_i[8*W-1:4*W];
         bypass_q    <= bus.csr_reg_set_i[8*W];
         gemm_done_q <= 1'b0;
         simd_done_q <= bus.csr_reg_set_i[8*W];
         cycle_cnt_q <= '0;
      end else begin
         if (gemm_vld && bus.gemm_cfg_ready_i) gemm_done_q <= 1'b1;
         if (simd_vld && bus.simd_cfg_ready_i) simd_done_q <= 1'b1;
         if (job_active && (cycle_cnt_q != '1)) cycle_cnt_q <= cycle_cnt_q + W'(1);
      end
   end

   // Read-only status: [0] cycle count, [1] bit0 busy / bit1 timeout error, higher words zero.
   always_comb begin
      bus.csr_reg_ro_set_o          = '0;
      bus.csr_reg_ro_set_o[W-1:0]   = cycle_cnt_q;
      bus.csr_reg_ro_set_o[W]       = job_active;
      bus.csr_reg_ro_set_o[W+1]     = err;
   end

   assign bus.csr_reg_set_ready_o = set_rdy;
   assign bus.gemm_cfg_o          = gemm_cfg_q;
   assign bus.gemm_cfg_valid_o    = gemm_vld;
   assign bus.simd_cfg_o          = simd_cfg_q;
   assign bus.simd_cfg_valid_o    = simd_vld;
   assign bus.bypass_simd_o       = bypass_q;
endmodule
